// File: rtl/ula_arb_pkg.sv
// Shared constants for the ula_arbiter slice: ULA pipeline depth, opcodes and
// the requester-ID width helper.
package ula_arb_pkg;

  localparam int ULA_LATENCY = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;

  // Bits needed to hold a requester ID; never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((32'(1) << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ula_arb_rr.sv
// Round-robin grant for ula_arbiter: the first valid requester at or after
// rr_ptr_q wins; the pointer moves past the winner on every grant.
module ula_arb_rr import ula_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               grant_vld_o
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int k;
    // NOTE: every output gets a default before the search so no path infers a latch.
    k           = 0;
    grant_o     = '0;
    grant_id_o  = '0;
    grant_vld_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_vld_o && req_valid_i[k]) begin
        grant_o[k]  = 1'b1;
        grant_id_o  = ID_W'(k);
        grant_vld_o = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld_o) begin
      rr_ptr_d = (int'(grant_id_o) == NUM_REQ - 1) ? '0 : grant_id_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one two-cycle ULA between NUM_REQ requesters and routes each result
// back by tag. Define ULA_ARB_STATS_EN to add saturating per-requester grant counters.
module ula_arbiter import ula_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_1_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_2_i,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel_i,
  output logic                          ula_valid_o,
  output logic [DATA_WIDTH-1:0]         ula_data_1_o,
  output logic [DATA_WIDTH-1:0]         ula_data_2_o,
  output logic [SEL_WIDTH-1:0]          ula_sel_o,
  input  logic                          ula_valid_i,
  input  logic [2*DATA_WIDTH-1:0]       ula_data_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [2*DATA_WIDTH-1:0]       rsp_data_o,
  output logic                          err_o
`ifdef ULA_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt_o
`endif
);

  localparam int ID_W = clog2(NUM_REQ);
  localparam logic [1:0] DRAIN_DONE = 2'(ULA_LATENCY + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_WIDTH < 1 || SEL_WIDTH < 1) begin : g_param_check
    $error("ula_arbiter: unsupported parameter set");
  end

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_id;
  logic                    grant_vld;

  logic                    ula_valid_q;
  logic [DATA_WIDTH-1:0]   ula_data_1_q, ula_data_2_q;
  logic [SEL_WIDTH-1:0]    ula_sel_q;
  logic [ID_W-1:0]         issue_id_q;
  tag_t                    tag_q [ULA_LATENCY];
  tag_t                    tail;
  logic [1:0]              drain_q;
  logic                    drain_active;
  logic [NUM_REQ-1:0]      rsp_hot;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [2*DATA_WIDTH-1:0] rsp_data_q;
  logic                    err_q, err_d;

  ula_arb_rr #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .grant_vld_o (grant_vld)
  );

  assign req_ready_o = grant;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ula_valid_q  <= 1'b0;
      ula_data_1_q <= '0;
      ula_data_2_q <= '0;
      ula_sel_q    <= '0;
      issue_id_q   <= '0;
    end else begin
      ula_valid_q <= grant_vld;
      if (grant_vld) begin
        ula_data_1_q <= req_data_1_i[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        ula_data_2_q <= req_data_2_i[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        ula_sel_q    <= req_sel_i[int'(grant_id)*SEL_WIDTH +: SEL_WIDTH];
        issue_id_q   <= grant_id;
      end
    end
  end

  // NOTE: the tag pipeline is reset on purpose; a stale valid bit would route ULA garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ULA_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: ula_valid_q, id: issue_id_q};
      for (int i = 1; i < ULA_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail = tag_q[ULA_LATENCY-1];

  // The ULA itself is never reset, so ignore its output until it has flushed.
  assign drain_active = (drain_q != DRAIN_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               drain_q <= '0;
    else if (drain_active) drain_q <= drain_q + 2'd1;
  end

  always_comb begin
    rsp_hot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_hot[k] = ula_valid_i && tail.vld && (int'(tail.id) == k);
    end
    err_d = err_q | (!drain_active && (ula_valid_i != tail.vld));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_hot;
      if (|rsp_hot) rsp_data_q <= ula_data_i;
      err_q <= err_d;
    end
  end

  assign ula_valid_o  = ula_valid_q;
  assign ula_data_1_o = ula_data_1_q;
  assign ula_data_2_o = ula_data_2_q;
  assign ula_sel_o    = ula_sel_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign err_o        = err_q;

`ifdef ULA_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_vld && int'(grant_id) == k && cnt_q[k] != '1) begin
          cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < NUM_REQ; k++) grant_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: behavioural ULA plus a queue-based model of grants,
// issue and tagged responses, driven by directed and $urandom stimulus.
module tb_ula_arbiter;
  import ula_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int RW = 2 * DW;
`ifdef ULA_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid_i, req_ready_o;
  logic [N*DW-1:0] req_data_1_i, req_data_2_i;
  logic [N*SW-1:0] req_sel_i;
  logic            ula_valid_o;
  logic [DW-1:0]   ula_data_1_o, ula_data_2_o;
  logic [SW-1:0]   ula_sel_o;
  logic            ula_valid_i;
  logic [RW-1:0]   ula_data_i;
  logic [N-1:0]    rsp_valid_o;
  logic [RW-1:0]   rsp_data_o;
  logic            err_o;
`ifdef ULA_ARB_STATS_EN
  logic [N*CW-1:0] grant_cnt_o;
`endif

  ula_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_1_i (req_data_1_i),
    .req_data_2_i (req_data_2_i),
    .req_sel_i    (req_sel_i),
    .ula_valid_o  (ula_valid_o),
    .ula_data_1_o (ula_data_1_o),
    .ula_data_2_o (ula_data_2_o),
    .ula_sel_o    (ula_sel_o),
    .ula_valid_i  (ula_valid_i),
    .ula_data_i   (ula_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .err_o        (err_o)
`ifdef ULA_ARB_STATS_EN
    ,
    .grant_cnt_o  (grant_cnt_o)
`endif
  );

  function automatic logic [RW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [SW-1:0] s);
    case (s)
      OP_ADD:  return RW'(a) + RW'(b);
      OP_SUB:  return RW'(a) - RW'(b);
      OP_INC:  return RW'(a) + RW'(1);
      default: return '0;
    endcase
  endfunction

  // Unresettable two-stage ULA; inj lets the bench force a stray valid.
  logic          u_v1 = 1'b0, u_v2 = 1'b0, inj = 1'b0;
  logic [RW-1:0] u_d1 = '0, u_d2 = '0;
  always @(posedge clk) begin
    u_v1 <= ula_valid_o;
    u_d1 <= alu(ula_data_1_o, ula_data_2_o, ula_sel_o);
    u_v2 <= u_v1;
    u_d2 <= u_d1;
  end
  assign ula_valid_i = u_v2 | inj;
  assign ula_data_i  = u_d2;

  logic [N-1:0]  s_valid;
  logic [DW-1:0] s_d1 [N];
  logic [DW-1:0] s_d2 [N];
  logic [SW-1:0] s_sel [N];

  typedef struct {
    int            due;
    int            id;
    logic [RW-1:0] data;
  } exp_t;

  exp_t          exp_q [$];
  int            ptr, since_rst, cyc;
  logic [RW-1:0] m_rsp_data;
  logic          m_err, m_ula_v;
  logic [DW-1:0] m_d1, m_d2;
  logic [SW-1:0] m_sel;
  int            m_cnt [N];
  int            n_total = 0;
  int            n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic apply();
    req_valid_i = s_valid;
    for (int k = 0; k < N; k++) begin
      req_data_1_i[k*DW +: DW] = s_d1[k];
      req_data_2_i[k*DW +: DW] = s_d2[k];
      req_sel_i[k*SW +: SW]    = s_sel[k];
    end
  endtask

  task automatic model_reset();
    ptr        = 0;
    exp_q.delete();
    m_rsp_data = '0;
    m_err      = 1'b0;
    since_rst  = 0;
    m_ula_v    = 1'b0;
    m_d1       = '0;
    m_d2       = '0;
    m_sel      = '0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endtask

  // One clock cycle: drive, optionally pulse reset, check at negedge, advance model.
  task automatic step(input bit rst_pulse, input bit inject);
    int            win;
    logic [N-1:0]  exp_ready, exp_rv;
    bit            due_next;
    exp_t          e;
    apply();
    inj = inject;
    if (rst_pulse) begin
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
    end
    @(negedge clk);
    win = -1;
    for (int i = 0; i < N; i++) begin
      int k = (ptr + i) % N;
      if (win < 0 && s_valid[k]) win = k;
    end
    exp_ready = (win >= 0) ? (N'(1) << win) : '0;
    check("req_ready", req_ready_o, exp_ready);
    check("ula_valid", ula_valid_o, m_ula_v);
    check("ula_data_1", ula_data_1_o, m_d1);
    check("ula_data_2", ula_data_2_o, m_d2);
    check("ula_sel", ula_sel_o, m_sel);
    exp_rv = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv     = N'(1) << exp_q[0].id;
      m_rsp_data = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check("rsp_valid", rsp_valid_o, exp_rv);
    check("rsp_data", rsp_data_o, m_rsp_data);
    check("err", err_o, m_err);
`ifdef ULA_ARB_STATS_EN
    for (int k = 0; k < N; k++) check("grant_cnt", grant_cnt_o[k*CW +: CW], CW'(m_cnt[k]));
`endif
    due_next = (exp_q.size() > 0 && exp_q[0].due == cyc + 1);
    if (since_rst >= ULA_LATENCY + 1 && (ula_valid_i != due_next)) m_err = 1'b1;
    if (win >= 0) begin
      m_ula_v = 1'b1;
      m_d1    = s_d1[win];
      m_d2    = s_d2[win];
      m_sel   = s_sel[win];
      e.due   = cyc + 4;
      e.id    = win;
      e.data  = alu(s_d1[win], s_d2[win], s_sel[win]);
      exp_q.push_back(e);
      ptr = (win + 1) % N;
      if (m_cnt[win] < (1 << CW) - 1) m_cnt[win]++;
    end else begin
      m_ula_v = 1'b0;
    end
    since_rst++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    s_valid = '0;
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic set_one(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [SW-1:0] s);
    s_valid    = '0;
    s_valid[k] = 1'b1;
    s_d1[k]    = a;
    s_d2[k]    = b;
    s_sel[k]   = s;
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < N; k++) begin
      s_d1[k]  = DW'($urandom);
      s_d2[k]  = DW'($urandom);
      s_sel[k] = SW'($urandom_range(0, 3));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    s_valid = '0;
    for (int k = 0; k < N; k++) begin
      s_d1[k]  = '0;
      s_d2[k]  = '0;
      s_sel[k] = '0;
    end
    apply();
    model_reset();
    cyc = 0;

    // Reset state, including combinational ready with pointer at zero.
    @(negedge clk);
    check("rst_ready_idle", req_ready_o, '0);
    check("rst_ula_valid", ula_valid_o, 1'b0);
    check("rst_ula_data", {ula_data_1_o, ula_data_2_o, ula_sel_o}, '0);
    check("rst_rsp_valid", rsp_valid_o, '0);
    check("rst_rsp_data", rsp_data_o, '0);
    check("rst_err", err_o, 1'b0);
    s_valid = 4'b0110;
    apply();
    #1;
    check("rst_ready_ptr0", req_ready_o, 4'b0010);
    s_valid = '0;
    apply();
    @(posedge clk);
    #1;
    rst = 1'b0;

    idle(4);

    set_one(1, 8'd200, 8'd100, OP_ADD);
    step(1'b0, 1'b0);
    idle(3);
    check("single_rsp_valid", rsp_valid_o, 4'b0010);
    check("single_rsp_data", rsp_data_o, 16'd300);
    idle(3);

    s_valid = '1;
    repeat (8) begin
      randomize_ops();
      step(1'b0, 1'b0);
    end
    idle(6);

    set_one(2, 8'd5, 8'd7, OP_SUB);
    step(1'b0, 1'b0);
    set_one(3, 8'd255, 8'd0, OP_INC);
    step(1'b0, 1'b0);
    idle(2);
    check("mixed_rsp0_valid", rsp_valid_o, 4'b0100);
    check("mixed_rsp0_data", rsp_data_o, 16'hFFFE);
    idle(1);
    check("mixed_rsp1_valid", rsp_valid_o, 4'b1000);
    check("mixed_rsp1_data", rsp_data_o, 16'h0100);
    idle(3);

    step(1'b0, 1'b1);
    idle(4);
    check("stray_err_sticky", err_o, 1'b1);

    set_one(0, 8'd11, 8'd22, OP_ADD);
    step(1'b0, 1'b0);
    set_one(1, 8'd33, 8'd44, OP_SUB);
    step(1'b0, 1'b0);
    s_valid = '0;
    step(1'b1, 1'b0);
    idle(6);
    set_one(3, 8'd10, 8'd20, OP_ADD);
    step(1'b0, 1'b0);
    idle(6);

    repeat (300) begin
      s_valid = N'($urandom_range(0, (1 << N) - 1));
      randomize_ops();
      step(1'b0, 1'b0);
    end
    idle(6);

`ifdef ULA_ARB_STATS_EN
    s_valid = '0;
    step(1'b1, 1'b0);
    idle(3);
    set_one(0, 8'd1, 8'd2, OP_ADD);
    repeat (5) step(1'b0, 1'b0);
    idle(1);
    check("stats_cnt0_5", grant_cnt_o[CW-1:0], CW'(5));
    set_one(0, 8'd3, 8'd4, OP_INC);
    repeat (15) step(1'b0, 1'b0);
    idle(6);
    check("stats_cnt0_sat", grant_cnt_o[CW-1:0], CW'(15));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
